// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_pkg                                                         |
// | Shared FSM state encoding and port identifiers for dmem_arbiter.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter_if                                                  |
// | Requester and datamem bus signals for dmem_arbiter.              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface dmem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     req0;
    logic                     we0;
    logic                     lock0;
    logic [ADDRESS_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0]    wdata0;
    logic                     gnt0;
    logic                     rvalid0;
    logic [DATA_WIDTH-1:0]    rdata0;
    logic                     err0;

    logic                     req1;
    logic                     we1;
    logic                     lock1;
    logic [ADDRESS_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0]    wdata1;
    logic                     gnt1;
    logic                     rvalid1;
    logic [DATA_WIDTH-1:0]    rdata1;
    logic                     err1;

    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0]    mem_wd;
    logic [DATA_WIDTH-1:0]    mem_rd;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        input  mem_rd,
        output gnt0, rvalid0, rdata0, err0,
        output gnt1, rvalid1, rdata1, err1,
        output mem_we, mem_a, mem_wd
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        output mem_rd,
        input  gnt0, rvalid0, rdata0, err0,
        input  gnt1, rvalid1, rdata1, err1,
        input  mem_we, mem_a, mem_wd
    );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arb2                                                          |
// | Two-way round-robin pick producing a one-hot grant.              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arb2 (
    input  wire logic [1:0] i_req,
    input  wire logic       i_rr_ptr,
    output logic      [1:0] o_gnt
);

    // Under contention the pointer names the winner.
    assign o_gnt[0] = i_req[0] & (~i_req[1] | ~i_rr_ptr);
    assign o_gnt[1] = i_req[1] & (~i_req[0] |  i_rr_ptr);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter                                                     |
// | Round-robin sharing of the data memory with bounded burst lock.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_AW        = 8,
    parameter int MAX_LOCK      = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    dmem_arbiter_if.slave bus
);

    localparam int                 c_CNT_W    = $clog2(MAX_LOCK + 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_MAX = c_CNT_W'(MAX_LOCK);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_rr_ptr;
    logic                     w_rr_ptr_nxt;
    logic [c_CNT_W-1:0]       r_lock_cnt;
    logic [c_CNT_W-1:0]       w_lock_cnt_nxt;
    logic [c_CNT_W-1:0]       w_lock_cnt_inc;
    logic [1:0]               r_block;
    logic [1:0]               w_block_nxt;

    logic [1:0]               w_req_arb;
    logic [1:0]               w_gnt;
    logic                     w_sel;
    logic                     w_beat;
    logic                     w_misal;
    logic                     w_we_sel;
    logic                     w_lock_sel;
    logic                     w_owner;
    logic                     w_owner_req;
    logic                     w_owner_lock;
    logic [ADDRESS_WIDTH-1:0] w_addr_sel;
    logic [DATA_WIDTH-1:0]    w_wdata_sel;

    logic [1:0]               r_rvalid;
    logic [1:0]               r_err;
    logic [DATA_WIDTH-1:0]    r_rdata0;
    logic [DATA_WIDTH-1:0]    r_rdata1;

    // A lock hides the other port from the arbiter entirely.
    always_comb begin
        w_req_arb = 2'b00;
        case (r_state)
            IDLE:    w_req_arb = {bus.req1, bus.req0};
            LOCK0:   w_req_arb = {1'b0, bus.req0};
            LOCK1:   w_req_arb = {bus.req1, 1'b0};
            default: w_req_arb = 2'b00;
        endcase
        if (rst) begin
            w_req_arb = 2'b00;
        end
    end

    rr_arb2 u_rr_arb2 (
        .i_req    (w_req_arb),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_gnt)
    );

    assign w_beat       = |w_gnt;
    assign w_sel        = w_gnt[1] ? PORT_DBG : PORT_CPU;
    assign w_addr_sel   = w_sel ? bus.addr1  : bus.addr0;
    assign w_wdata_sel  = w_sel ? bus.wdata1 : bus.wdata0;
    assign w_we_sel     = w_sel ? bus.we1    : bus.we0;
    assign w_lock_sel   = w_sel ? bus.lock1  : bus.lock0;
    assign w_misal      = |w_addr_sel[1:0];

    assign w_owner      = (r_state == LOCK1);
    assign w_owner_req  = w_owner ? bus.req1  : bus.req0;
    assign w_owner_lock = w_owner ? bus.lock1 : bus.lock0;

    assign w_lock_cnt_inc = r_lock_cnt + c_CNT_W'(1);

    assign bus.gnt0   = w_gnt[0];
    assign bus.gnt1   = w_gnt[1];
    assign bus.mem_we = w_beat & w_we_sel & ~w_misal;
    assign bus.mem_a  = ADDRESS_WIDTH'(w_addr_sel[MEM_AW+1:2]);
    assign bus.mem_wd = w_wdata_sel;

    generate
        if (ADDRESS_WIDTH > MEM_AW + 2) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^w_addr_sel[ADDRESS_WIDTH-1:MEM_AW+2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= PORT_CPU;
            r_lock_cnt <= '0;
            r_block    <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_block    <= w_block_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_lock_cnt_nxt = r_lock_cnt;
        w_block_nxt    = r_block;
        case (r_state)
            IDLE: begin
                if (w_beat) begin
                    w_rr_ptr_nxt = ~w_sel;
                    // A port forced out by timeout spends one plain beat before it may lock again.
                    if (r_block[w_sel]) begin
                        w_block_nxt[w_sel] = 1'b0;
                    end else if (w_lock_sel) begin
                        w_state_nxt    = w_sel ? LOCK1 : LOCK0;
                        w_lock_cnt_nxt = c_CNT_W'(1);
                    end
                end
            end
            LOCK0, LOCK1: begin
                if (!w_owner_req) begin
                    w_state_nxt    = IDLE;
                    w_lock_cnt_nxt = '0;
                end else if (w_lock_cnt_inc >= c_LOCK_MAX) begin
                    w_state_nxt          = IDLE;
                    w_lock_cnt_nxt       = '0;
                    w_rr_ptr_nxt         = ~w_owner;
                    w_block_nxt[w_owner] = 1'b1;
                end else if (!w_owner_lock) begin
                    w_state_nxt    = IDLE;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = w_lock_cnt_inc;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    // Read data is captured here so no output path reaches mem_rd combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 2'b00;
            r_err    <= 2'b00;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_rvalid <= w_gnt;
            r_err    <= w_gnt & {2{w_misal}};
            if (w_gnt[0]) begin
                r_rdata0 <= (bus.we0 || w_misal) ? '0 : bus.mem_rd;
            end
            if (w_gnt[1]) begin
                r_rdata1 <= (bus.we1 || w_misal) ? '0 : bus.mem_rd;
            end
        end
    end

    assign bus.rvalid0 = r_rvalid[0];
    assign bus.rvalid1 = r_rvalid[1];
    assign bus.err0    = r_err[0];
    assign bus.err1    = r_err[1];
    assign bus.rdata0  = r_rdata0;
    assign bus.rdata1  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_arbiter                                                  |
// | Directed and random checks of dmem_arbiter against a model.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_dmem_arbiter;

    localparam int c_MAX_LOCK = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem_arbiter #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_AW        (8),
        .MAX_LOCK      (c_MAX_LOCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Stand-in datamem: combinational read, write on posedge.
    logic [31:0] mem [256] = '{default: 32'h0};
    assign bus.mem_rd = mem[bus.mem_a[7:0]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a[7:0]] <= bus.mem_wd;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_owner;
    int          m_cnt;
    bit          m_rr;
    bit          m_blk [2];
    logic [31:0] ref_mem [256] = '{default: 32'h0};
    logic        e_rv  [2];
    logic        e_err [2];
    logic [31:0] e_rd  [2];

    logic        t_req [2];
    logic        t_we  [2];
    logic        t_lk  [2];
    logic [31:0] t_ad  [2];
    logic [31:0] t_wd  [2];

    logic        o_g0, o_g1, o_we;
    logic [31:0] o_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic l,
                            input logic [31:0] a, input logic [31:0] d);
        t_req[p] = r; t_we[p] = w; t_lk[p] = l; t_ad[p] = a; t_wd[p] = d;
    endtask

    task automatic clear_ports();
        set_port(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic apply();
        bus.req0 = t_req[0]; bus.we0 = t_we[0]; bus.lock0 = t_lk[0];
        bus.addr0 = t_ad[0]; bus.wdata0 = t_wd[0];
        bus.req1 = t_req[1]; bus.we1 = t_we[1]; bus.lock1 = t_lk[1];
        bus.addr1 = t_ad[1]; bus.wdata1 = t_wd[1];
    endtask

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_rr = 1'b0;
        m_blk[0] = 1'b0; m_blk[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            e_rv[p] = 1'b0; e_err[p] = 1'b0; e_rd[p] = 32'h0;
        end
    endtask

    // One beat: drive on negedge, check combinational outputs, then registered ones after posedge.
    task automatic step();
        int   g;
        int   ps;
        int   idx;
        logic mis;
        @(negedge clk);
        apply();
        #1;
        if (m_owner < 0) begin
            if (t_req[0] && t_req[1]) g = m_rr ? 1 : 0;
            else if (t_req[0])        g = 0;
            else if (t_req[1])        g = 1;
            else                      g = -1;
        end else begin
            g = t_req[m_owner] ? m_owner : -1;
        end
        ps  = (g == 1) ? 1 : 0;
        idx = int'(t_ad[ps][9:2]);
        mis = (g >= 0) && (t_ad[ps][1:0] != 2'b00);

        o_g0 = bus.gnt0; o_g1 = bus.gnt1; o_we = bus.mem_we; o_a = bus.mem_a;
        chk("gnt0",   32'(bus.gnt0),   32'(g == 0));
        chk("gnt1",   32'(bus.gnt1),   32'(g == 1));
        chk("mem_we", 32'(bus.mem_we), 32'((g >= 0) && t_we[ps] && !mis));
        chk("mem_a",  bus.mem_a,       {24'h0, t_ad[ps][9:2]});
        chk("mem_wd", bus.mem_wd,      t_wd[ps]);

        for (int p = 0; p < 2; p++) begin
            e_rv[p]  = (g == p);
            e_err[p] = (g == p) && mis;
            if (g == p) e_rd[p] = (mis || t_we[p]) ? 32'h0 : ref_mem[idx];
        end
        if (g >= 0 && t_we[ps] && !mis) ref_mem[idx] = t_wd[ps];

        if (m_owner < 0) begin
            if (g >= 0) begin
                m_rr = (g == 0);
                if (m_blk[g])      m_blk[g] = 1'b0;
                else if (t_lk[g]) begin m_owner = g; m_cnt = 1; end
            end
        end else if (g < 0) begin
            m_owner = -1; m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt >= c_MAX_LOCK) begin
                m_rr = (g == 0); m_blk[g] = 1'b1; m_owner = -1; m_cnt = 0;
            end else if (!t_lk[g]) begin
                m_owner = -1; m_cnt = 0;
            end
        end

        @(posedge clk);
        #1;
        chk("rvalid0", 32'(bus.rvalid0), 32'(e_rv[0]));
        chk("rvalid1", 32'(bus.rvalid1), 32'(e_rv[1]));
        if (e_rv[0]) chk("err0", 32'(bus.err0), 32'(e_err[0]));
        if (e_rv[1]) chk("err1", 32'(bus.err1), 32'(e_err[1]));
        chk("rdata0", bus.rdata0, e_rd[0]);
        chk("rdata1", bus.rdata1, e_rd[1]);
    endtask

    // Asynchronous reset asserted between edges, with current inputs still applied.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_gnt0",    32'(bus.gnt0),    32'h0);
        chk("rst_gnt1",    32'(bus.gnt1),    32'h0);
        chk("rst_mem_we",  32'(bus.mem_we),  32'h0);
        chk("rst_rvalid0", 32'(bus.rvalid0), 32'h0);
        chk("rst_rvalid1", 32'(bus.rvalid1), 32'h0);
        chk("rst_rdata0",  bus.rdata0,       32'h0);
        chk("rst_rdata1",  bus.rdata1,       32'h0);
        clear_ports();
        apply();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_ports();
        set_port(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h1111_2222);
        apply();
        #3;
        chk("init_gnt0",    32'(bus.gnt0),    32'h0);
        chk("init_mem_we",  32'(bus.mem_we),  32'h0);
        chk("init_rvalid0", 32'(bus.rvalid0), 32'h0);
        chk("init_rdata0",  bus.rdata0,       32'h0);
        clear_ports();
        apply();
        @(negedge clk);
        rst = 1'b0;

        // Write then read back on port 0
        set_port(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        step();
        chk("wr_mem_a",  o_a,              32'd4);
        chk("wr_mem_we", 32'(o_we),        32'h1);
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        step();
        chk("rd_rvalid0", 32'(bus.rvalid0), 32'h1);
        chk("rd_rdata0",  bus.rdata0,       32'hDEAD_BEEF);
        chk("rd_err0",    32'(bus.err0),    32'h0);

        // Contention from reset alternates starting with port 0
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("alt_gnt0", 32'(o_g0), 32'(i % 2 == 0));
            chk("alt_gnt1", 32'(o_g1), 32'(i % 2 == 1));
        end

        // Port 1 locked burst of 4 beats while port 0 waits
        set_port(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
            set_port(1, 1'b1, 1'b0, (i < 3), 32'h30, 32'h0);
            step();
            chk("burst_gnt1", 32'(o_g1), 32'h1);
            chk("burst_gnt0", 32'(o_g0), 32'h0);
        end
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
        step();
        chk("burst_after_gnt0", 32'(o_g0), 32'h1);

        // Lock timeout at MAX_LOCK beats
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
        for (int i = 0; i < c_MAX_LOCK; i++) begin
            step();
            chk("tmo_gnt0", 32'(o_g0), 32'h1);
        end
        step();
        chk("tmo_then_gnt1", 32'(o_g1), 32'h1);
        step();
        chk("tmo_then_gnt0", 32'(o_g0), 32'h1);
        step();
        chk("tmo_alt_gnt1", 32'(o_g1), 32'h1);

        // Misaligned write must not disturb memory
        clear_ports();
        step();
        set_port(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0000_1234);
        step();
        set_port(1, 1'b1, 1'b1, 1'b0, 32'h13, 32'h0000_0055);
        step();
        chk("mis_mem_we",  32'(o_we),        32'h0);
        chk("mis_rvalid1", 32'(bus.rvalid1), 32'h1);
        chk("mis_err1",    32'(bus.err1),    32'h1);
        chk("mis_rdata1",  bus.rdata1,       32'h0);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        step();
        chk("mis_old_word", bus.rdata1, 32'h0000_1234);

        // Reset while locked with a response in flight
        clear_ports();
        set_port(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
        step();
        set_port(0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h0000_0077);
        apply();
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        step();
        chk("post_rst_gnt0", 32'(o_g0), 32'h1);
        step();
        chk("post_rst_gnt1", 32'(o_g1), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                logic [31:0] a;
                a      = $urandom();
                a[9:2] = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
                set_port(p, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                         ($urandom_range(0, 2) != 0), a, $urandom());
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (word-addressed, combinational read, write on posedge clk when WE=1) between two requesters.
  - Port 0: CPU load/store stage.
  - Port 1: loader/debug port that preloads or inspects memory.
- Arbitration is round-robin, one beat per cycle, with an optional bounded lock for bursts.
- Read data is returned one cycle after the beat is accepted, with a misaligned-address error check.
- Sits between the requesters and the datamem instance in the full CPU top level.

Parameters:
- ADDRESS_WIDTH, 32, requester byte-address width.
- DATA_WIDTH, 32, data width.
- MEM_AW, 8, memory word-index width (256 words).
- MAX_LOCK, 8, maximum consecutive beats a locking port may hold the memory.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous active-high reset
- req0  input  1  port 0 request (beat pending)
- we0  input  1  port 0 write enable
- lock0  input  1  port 0 requests ownership past the current beat
- addr0  input  ADDRESS_WIDTH  port 0 byte address
- wdata0  input  DATA_WIDTH  port 0 write data
- gnt0  output  1  port 0 beat accepted this cycle
- rvalid0  output  1  port 0 response valid (one cycle after gnt0)
- rdata0  output  DATA_WIDTH  port 0 read data
- err0  output  1  port 0 misaligned error, qualified by rvalid0
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1, err1: same as port 0, for port 1
- mem_we  output  1  to datamem WE
- mem_a  output  ADDRESS_WIDTH  to datamem A, word index zero-extended
- mem_wd  output  DATA_WIDTH  to datamem WD
- mem_rd  input  DATA_WIDTH  from datamem RD

Behaviour:
- Reset values (asynchronous, on rst=1):
  - state=IDLE, rr_ptr=0 (port 0 preferred), lock_cnt=0.
  - rvalid0/1=0, rdata0/1=0, err0/1=0.
  - gnt0/1=0 and mem_we=0 while rst=1.
- FSM states: IDLE, LOCK0, LOCK1.
- Grant rules (gnt is combinational from state, req and rr_ptr):
  - IDLE, single request: that port is granted.
  - IDLE, both requesting: the port equal to rr_ptr is granted.
  - LOCKx: only port x can be granted; the other port waits regardless of req.
- rr_ptr update: on every accepted beat in IDLE, rr_ptr becomes the non-granted port.
- Memory drive: mem_a, mem_wd and we come from the granted port; when no port is granted, port 0's fields are passed through with mem_we=0.
- Address mapping: mem_a = {zeros, addr[MEM_AW+1:2]}; addr bits above MEM_AW+1 are ignored.
- Misaligned beat (addr[1:0]!=0):
  - The beat is still granted, but mem_we is forced to 0.
  - The next cycle gives rvalid=1, err=1, rdata=0.
- Response timing:
  - rvalid for the granted port is registered, exactly 1 cycle after gnt, for reads and writes alike.
  - rdata is a registered capture of mem_rd on reads; rdata=0 on writes and on err.
  - rdata holds its value until the next response to that port.
- Read-after-write to the same word in consecutive beats returns the new data, because the write commits at the same edge the next beat's read is issued.
- Lock transitions:
  - IDLE -> LOCKx: accepted beat with lockx=1. lock_cnt is loaded with 1 at that edge.
  - In LOCKx, each accepted beat increments lock_cnt.
  - LOCKx -> IDLE when either:
    - an accepted beat has lockx=0, or
    - reqx=0 in any cycle while in LOCKx (owner abandoned).
  - Forced release on timeout: when lock_cnt reaches MAX_LOCK on an accepted beat, LOCKx -> IDLE and rr_ptr is set to the other port, even if lockx=1.
  - A port that has just been forced out cannot re-lock until it has been granted again from IDLE.
- lock_cnt is cleared on every return to IDLE.
- lock has no effect unless req is also asserted.
- Combinational-loop rule: no output depends combinationally on mem_rd.
- Simultaneous events: a lock release and a new request from the other port in the same cycle give the other port the grant next cycle, not the same cycle.
- Reset during a pending response: the response is dropped and rvalid=0.

Decomposition:
- Shared package dmem_pkg:
  - typedef enum state_t {IDLE, LOCK0, LOCK1}
  - localparam PORT_CPU=0, PORT_DBG=1
- Natural sub-module rr_arb2: 2-way round-robin pick from req[1:0] and rr_ptr, producing a one-hot grant; combinational.
- FSM, lock counter and response registers stay in dmem_arbiter.

Test Plan:
- Reset then write then read on port 0:
  - Stimulus: port 0 writes addr=0x10, wdata=0xDEADBEEF; next cycle port 0 reads addr 0x10.
  - Required: mem_a=4, mem_we=1 on the write beat; rvalid0 one cycle after each beat; the read returns rdata0=0xDEADBEEF, err0=0.
- Contention:
  - Stimulus: req0=req1=1 continuously, both reads.
  - Required: grants alternate 0,1,0,1; first gnt0 after reset; each rvalid arrives one cycle after its own gnt.
- Lock burst:
  - Stimulus: port 1 with lock1=1 for 3 beats, then lock1=0 on the 4th beat, while req0=1 throughout.
  - Required: gnt1 on 4 consecutive cycles, gnt0=0 during them, gnt0 on the 5th cycle.
- Lock timeout:
  - Stimulus: MAX_LOCK=8, port 0 holds lock0=1 and req0=1 indefinitely, req1=1.
  - Required: exactly 8 consecutive gnt0, then gnt1, then alternation resumes.
- Misaligned write:
  - Stimulus: port 1 writes addr=0x13, wdata=0x55.
  - Required: mem_we=0; next cycle rvalid1=1, err1=1, rdata1=0; a later read of word 4 shows the old contents.
- Asynchronous reset mid-operation:
  - Stimulus: assert rst between clock edges while in LOCK0 with a response pending.
  - Required: immediately rvalid0=0, gnt0=0, mem_we=0; after release the FSM is in IDLE and rr_ptr favours port 0.
